// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: operand-forwarding select codes,
// default datapath widths and the layout of the EX/MEM/WB control bundle.
package cpu_pkg;

  localparam int DEFAULT_DATA_W     = 64;
  localparam int DEFAULT_REG_ADDR_W = 5;

  // ALU operand mux select: where the EX stage takes a source operand from.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Control bundle carried opaquely through ID/EX; consumed by later stages.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
  } ex_ctrl_t;

  localparam int DEFAULT_CTRL_W = $bits(ex_ctrl_t);

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selects for both ALU source operands of the
// instruction currently in EX. The younger EX/MEM producer wins over MEM/WB.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    forward_a = FWD_REG;
    forward_b = FWD_REG;

    // x0 is hard-wired to zero, so a write to it is never a real producer.
    if (ex_valid && ex_rs1 != '0) begin
      if (exmem_reg_write && exmem_rd == ex_rs1)      forward_a = FWD_EXMEM;
      else if (memwb_reg_write && memwb_rd == ex_rs1) forward_a = FWD_MEMWB;
    end

    if (ex_valid && ex_rs2 != '0) begin
      if (exmem_reg_write && exmem_rd == ex_rs2)      forward_b = FWD_EXMEM;
      else if (memwb_reg_write && memwb_rd == ex_rs2) forward_b = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with bubble insertion on flush or load-use stall,
// plus the load-use stall detector and the operand forwarding unit.
module id_ex_forward_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int CTRL_W     = DEFAULT_CTRL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_rs2_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_mem_read,
  output logic                  ex_reg_write,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall
);

  // A load in EX cannot forward its data in time to a dependent instruction in ID.
  assign stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else if (flush || stall) begin
      // Bubble: data fields are zeroed too so a killed slot never matches a forward.
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_reg_write <= id_valid && id_reg_write;
      ex_ctrl      <= id_ctrl;
    end
  end

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_forward_unit (
    .ex_valid        (ex_valid),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .forward_a       (forward_a),
    .forward_b       (forward_b)
  );

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed hazard scenarios plus
// randomized traffic checked against a behavioural model of the EX slot.
module tb_id_ex_forward_stage;

  localparam int DATA_W = 64;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
  logic              id_mem_read, id_reg_write;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0]   exmem_rd, memwb_rd;
  logic              exmem_reg_write, memwb_reg_write;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic              ex_mem_read, ex_reg_write;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [1:0]        forward_a, forward_b;
  logic              stall;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic              mem_read;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t m;    // expected content of the EX slot
  ex_t obs;

  always #5 clk = ~clk;

  assign obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_reg_write, ex_ctrl};

  id_ex_forward_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall)
  );

  // ---------------- reference model ----------------
  // A load sitting in EX whose result a real ID instruction needs.
  function automatic logic exp_stall();
    if (!(m.valid && m.mem_read) || m.rd == 0 || !id_valid) return 1'b0;
    return (m.rd == id_rs1) || (m.rd == id_rs2);
  endfunction

  // Scan producers youngest first; the first writer of rs supplies the operand.
  function automatic logic [1:0] exp_fwd(input logic [RA_W-1:0] rs);
    logic            wr   [2];
    logic [RA_W-1:0] rd   [2];
    logic [1:0]      code [2];
    wr   = '{exmem_reg_write, memwb_reg_write};
    rd   = '{exmem_rd, memwb_rd};
    code = '{2'b10, 2'b01};
    if (!m.valid || rs == 0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (wr[i] && rd[i] == rs) return code[i];
    return 2'b00;
  endfunction

  function automatic ex_t next_slot(input logic kill);
    ex_t n;
    n = '0;
    if (!kill) begin
      n.valid     = id_valid;
      n.pc        = id_pc;
      n.rs1_data  = id_rs1_data;
      n.rs2_data  = id_rs2_data;
      n.imm       = id_imm;
      n.rs1       = id_rs1;
      n.rs2       = id_rs2;
      n.rd        = id_rd;
      n.mem_read  = id_valid & id_mem_read;
      n.reg_write = id_valid & id_reg_write;
      n.ctrl      = id_ctrl;
    end
    return n;
  endfunction

  // Advance one clock; the model sees the same pre-edge inputs as the DUT.
  task automatic tick();
    ex_t n;
    n = next_slot(flush || exp_stall());
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic [RA_W-1:0] rd, input logic mr, input logic rw);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_mem_read  = mr;
    id_reg_write = rw;
    id_pc        = {$urandom, $urandom};
    id_rs1_data  = {$urandom, $urandom};
    id_rs2_data  = {$urandom, $urandom};
    id_imm       = {$urandom, $urandom};
    id_ctrl      = 8'($urandom);
  endtask

  task automatic flush_ex();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    exmem_rd = 5'd1; exmem_reg_write = 1'b1;
    memwb_rd = 5'd2; memwb_reg_write = 1'b1;
    m = '0;
    #3;
    tests++;
    if (obs !== ex_t'(0)) begin
      fails++;
      $display("FAIL reset_regs: got %h want 0", obs);
    end
    tests++;
    if ({forward_a, forward_b, stall} !== 5'b0) begin
      fails++;
      $display("FAIL reset_comb: got fa=%b fb=%b st=%b want 00 00 0", forward_a, forward_b, stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_midrun();
    flush_ex();
    drive_id(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1);
    tick();
    tests++;
    if (obs !== m || ex_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrun_load: got %h want %h", obs, m);
    end
    // ID reads the load's rd, so the stall is live when reset hits mid-cycle.
    id_rs1 = 5'd6;
    exmem_rd = 5'd4; exmem_reg_write = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== ex_t'(0)) begin
      fails++;
      $display("FAIL midrun_reset_regs: got %h want 0", obs);
    end
    tests++;
    if ({forward_a, forward_b, stall} !== 5'b0) begin
      fails++;
      $display("FAIL midrun_reset_comb: got fa=%b fb=%b st=%b want 00 00 0", forward_a, forward_b, stall);
    end
    m = '0;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_exmem_priority();
    flush_ex();
    drive_id(1'b1, 5'd5, 5'd6, 5'd1, 1'b0, 1'b1);
    tick();
    exmem_rd = 5'd5; exmem_reg_write = 1'b1;
    memwb_rd = 5'd5; memwb_reg_write = 1'b1;
    #2;
    tests++;
    if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
      fails++;
      $display("FAIL exmem_priority: got fa=%b fb=%b want 10 00", forward_a, forward_b);
    end
  endtask

  task automatic test_memwb();
    flush_ex();
    drive_id(1'b1, 5'd1, 5'd6, 5'd2, 1'b0, 1'b1);
    tick();
    exmem_rd = 5'd7; exmem_reg_write = 1'b1;
    memwb_rd = 5'd6; memwb_reg_write = 1'b1;
    #2;
    tests++;
    if (forward_b !== 2'b01) begin
      fails++;
      $display("FAIL memwb_fwd: got fb=%b want 01", forward_b);
    end
    drive_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, 1'b1);
    tick();
    memwb_rd = 5'd0; memwb_reg_write = 1'b1;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1;
    #2;
    tests++;
    if (forward_b !== 2'b00) begin
      fails++;
      $display("FAIL x0_no_fwd: got fb=%b want 00", forward_b);
    end
  endtask

  task automatic test_load_use();
    flush_ex();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd7, 5'd3, 5'd8, 1'b0, 1'b1);
    #2;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall: got %b want 1", stall);
    end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || obs !== m) begin
      fails++;
      $display("FAIL load_use_bubble: got %h want %h", obs, m);
    end
    // The load moves on to EX/MEM while ID holds the dependent instruction.
    exmem_rd = 5'd3; exmem_reg_write = 1'b1;
    #2;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL load_use_one_cycle: got stall=%b want 0", stall);
    end
    tick();
    exmem_rd = 5'd0; exmem_reg_write = 1'b0;
    memwb_rd = 5'd3; memwb_reg_write = 1'b1;
    #2;
    tests++;
    if (obs !== m || ex_rs2 !== 5'd3 || forward_b !== 2'b01 || forward_a !== 2'b00) begin
      fails++;
      $display("FAIL load_use_resume: got rs2=%0d fa=%b fb=%b want rs2=3 fa=00 fb=01",
               ex_rs2, forward_a, forward_b);
    end
  endtask

  task automatic test_flush_stall();
    flush_ex();
    drive_id(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd4, 5'd9, 5'd11, 1'b0, 1'b1);
    flush = 1'b1;
    #2;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL flush_stall_pre: got stall=%b want 1", stall);
    end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || obs !== m) begin
      fails++;
      $display("FAIL flush_stall_bubble: got valid=%b ctrl=%h want 0 00", ex_valid, ex_ctrl);
    end
    flush = 1'b0;
    drive_id(1'b1, 5'd12, 5'd13, 5'd10, 1'b0, 1'b1);
    tick();
    tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || obs !== m) begin
      fails++;
      $display("FAIL flush_resume: got %h want %h", obs, m);
    end
  endtask

  task automatic test_invalid_id();
    flush_ex();
    drive_id(1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    tests++;
    if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_valid !== 1'b0) begin
      fails++;
      $display("FAIL invalid_ctrl: got v=%b rw=%b mr=%b want 0 0 0", ex_valid, ex_reg_write, ex_mem_read);
    end
    // The non-instruction advances to EX/MEM carrying its (cleared) write enable.
    exmem_rd = 5'd9; exmem_reg_write = m.reg_write;
    drive_id(1'b1, 5'd9, 5'd1, 5'd14, 1'b0, 1'b1);
    tick();
    memwb_rd = 5'd9; memwb_reg_write = 1'b0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b0;
    #2;
    tests++;
    if (forward_a !== 2'b00) begin
      fails++;
      $display("FAIL invalid_no_fwd: got fa=%b want 00", forward_a);
    end
  endtask

  task automatic test_random();
    flush_ex();
    for (int i = 0; i < 400; i++) begin
      drive_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      flush           = ($urandom_range(0, 7) == 0);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_reg_write = 1'($urandom);
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_reg_write = 1'($urandom);
      #2;
      tests++;
      if ({forward_a, forward_b, stall} !== {exp_fwd(m.rs1), exp_fwd(m.rs2), exp_stall()}) begin
        fails++;
        $display("FAIL rand_comb[%0d]: got fa=%b fb=%b st=%b want fa=%b fb=%b st=%b", i,
                 forward_a, forward_b, stall, exp_fwd(m.rs1), exp_fwd(m.rs2), exp_stall());
      end
      tick();
      tests++;
      if (obs !== m) begin
        fails++;
        $display("FAIL rand_regs[%0d]: got %h want %h", i, obs, m);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exmem_priority();
    test_memwb();
    test_load_use();
    test_flush_stall();
    test_invalid_id();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
